// File: rtl/cdb_arbiter.sv
// Round-robin arbiter moving buffered FU results onto the registered common data bus.
// Define CDB_ARB_PERF_EN to add per-FU saturating stall counters (perf_stall_cnt).
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 5
`endif

module cdb_arbiter #(
   parameter  int FU_NUM = 3,
   parameter  int XLEN   = `XLEN,
   parameter  int TAG_W  = `ROB_TAG_LEN,
   localparam int SRC_W  = $clog2(FU_NUM)
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    squash,
   input  logic [FU_NUM-1:0]       fu_valid,
   input  logic [FU_NUM*TAG_W-1:0] fu_tag,
   input  logic [FU_NUM*XLEN-1:0]  fu_value,
   output logic [FU_NUM-1:0]       fu_ready,
   output logic                    cdb_valid,
   output logic [TAG_W-1:0]        cdb_tag,
   output logic [XLEN-1:0]         cdb_value,
   output logic [SRC_W-1:0]        cdb_src
`ifdef CDB_ARB_PERF_EN
   ,
   output logic [FU_NUM*16-1:0]    perf_stall_cnt
`endif
);

   logic [FU_NUM-1:0] buf_valid_q, buf_valid_d;
   logic [TAG_W-1:0]  buf_tag_q   [FU_NUM];
   logic [XLEN-1:0]   buf_value_q [FU_NUM];
   logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;

   logic              cdb_valid_q;
   logic [TAG_W-1:0]  cdb_tag_q;
   logic [XLEN-1:0]   cdb_value_q;
   logic [SRC_W-1:0]  cdb_src_q;

   logic [FU_NUM-1:0] grant_vec;
   logic [FU_NUM-1:0] load_vec;
   logic [SRC_W-1:0]  grant_idx;
   logic              grant_any;

   // Two passes give the wrapped search: indices at/after rr_ptr first, then the rest.
   // NOTE: blocking assignments in combinational logic, and every output gets a
   // default before any conditional write so no latch is inferred.
   always_comb begin
      grant_vec = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      for (int i = 0; i < FU_NUM; i++) begin
         if (!grant_any && buf_valid_q[i] && (i >= int'(rr_ptr_q))) begin
            grant_any    = 1'b1;
            grant_vec[i] = 1'b1;
            grant_idx    = SRC_W'(i);
         end
      end
      for (int i = 0; i < FU_NUM; i++) begin
         if (!grant_any && buf_valid_q[i] && (i < int'(rr_ptr_q))) begin
            grant_any    = 1'b1;
            grant_vec[i] = 1'b1;
            grant_idx    = SRC_W'(i);
         end
      end
   end

   assign fu_ready = ~buf_valid_q | grant_vec;

   // Tag 0 completes the handshake but is never buffered.
   always_comb begin
      load_vec = '0;
      for (int i = 0; i < FU_NUM; i++) begin
         load_vec[i] = fu_valid[i] & fu_ready[i] & (fu_tag[i*TAG_W +: TAG_W] != '0);
      end
   end

   assign buf_valid_d = (buf_valid_q & ~grant_vec) | load_vec;
   assign rr_ptr_d    = (grant_idx == SRC_W'(FU_NUM - 1)) ? '0 : grant_idx + SRC_W'(1);

   // NOTE: all flop updates use non-blocking assignments so every register samples
   // the pre-edge value of every other register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         buf_valid_q <= '0;
         rr_ptr_q    <= '0;
         cdb_valid_q <= 1'b0;
         cdb_tag_q   <= '0;
         cdb_value_q <= '0;
         cdb_src_q   <= '0;
      end else if (squash) begin
         buf_valid_q <= '0;
         cdb_valid_q <= 1'b0;
      end else begin
         buf_valid_q <= buf_valid_d;
         cdb_valid_q <= grant_any;
         if (grant_any) begin
            cdb_tag_q   <= buf_tag_q[grant_idx];
            cdb_value_q <= buf_value_q[grant_idx];
            cdb_src_q   <= grant_idx;
            rr_ptr_q    <= rr_ptr_d;
         end
      end
   end

   // NOTE: payload storage has no reset; buf_valid_q alone qualifies its contents.
   always_ff @(posedge clock) begin
      for (int i = 0; i < FU_NUM; i++) begin
         if (load_vec[i]) begin
            buf_tag_q[i]   <= fu_tag[i*TAG_W +: TAG_W];
            buf_value_q[i] <= fu_value[i*XLEN +: XLEN];
         end
      end
   end

   assign cdb_valid = cdb_valid_q;
   assign cdb_tag   = cdb_tag_q;
   assign cdb_value = cdb_value_q;
   assign cdb_src   = cdb_src_q;

`ifdef CDB_ARB_PERF_EN
   logic [15:0] stall_cnt_q [FU_NUM];

   // Counts cycles an FU is held off; survives squash, cleared only by reset.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < FU_NUM; i++) stall_cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < FU_NUM; i++) begin
            if (fu_valid[i] && !fu_ready[i] && (stall_cnt_q[i] != 16'hFFFF)) begin
               stall_cnt_q[i] <= stall_cnt_q[i] + 16'd1;
            end
         end
      end
   end

   for (genvar g = 0; g < FU_NUM; g++) begin : g_perf_out
      assign perf_stall_cnt[g*16 +: 16] = stall_cnt_q[g];
   end
`else
   // Stall counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: expected broadcasts are queued as stimulus is
// driven and compared against every CDB broadcast the DUT makes.
module tb_cdb_arbiter;
   localparam int FU_NUM = 3;
   localparam int XLEN   = 32;
   localparam int TAG_W  = 5;
   localparam int SRC_W  = 2;

   logic                    clock = 1'b0;
   logic                    reset = 1'b1;
   logic                    squash = 1'b0;
   logic [FU_NUM-1:0]       fu_valid = '0;
   logic [FU_NUM*TAG_W-1:0] fu_tag = '0;
   logic [FU_NUM*XLEN-1:0]  fu_value = '0;
   logic [FU_NUM-1:0]       fu_ready;
   logic                    cdb_valid;
   logic [TAG_W-1:0]        cdb_tag;
   logic [XLEN-1:0]         cdb_value;
   logic [SRC_W-1:0]        cdb_src;
`ifdef CDB_ARB_PERF_EN
   logic [FU_NUM*16-1:0]    perf_stall_cnt;
`endif

   typedef struct {
      logic [TAG_W-1:0] tag;
      logic [XLEN-1:0]  value;
      logic [SRC_W-1:0] src;
   } bc_t;

   bc_t sb [$];
   int  n_checks = 0;
   int  n_pass   = 0;
   int  cycles;

   always #5 clock = ~clock;

   cdb_arbiter #(.FU_NUM(FU_NUM), .XLEN(XLEN), .TAG_W(TAG_W)) dut (
      .clock     (clock),
      .reset     (reset),
      .squash    (squash),
      .fu_valid  (fu_valid),
      .fu_tag    (fu_tag),
      .fu_value  (fu_value),
      .fu_ready  (fu_ready),
      .cdb_valid (cdb_valid),
      .cdb_tag   (cdb_tag),
      .cdb_value (cdb_value),
      .cdb_src   (cdb_src)
`ifdef CDB_ARB_PERF_EN
      ,
      .perf_stall_cnt (perf_stall_cnt)
`endif
   );

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic present(input int fu, input logic v, input logic [TAG_W-1:0] t,
                          input logic [XLEN-1:0] val);
      fu_valid[fu]                = v;
      fu_tag[fu*TAG_W +: TAG_W]   = t;
      fu_value[fu*XLEN +: XLEN]   = val;
   endtask

   task automatic idle();
      fu_valid = '0;
      fu_tag   = '0;
      fu_value = '0;
   endtask

   task automatic expect_bc(input int tag, input int src);
      bc_t e;
      e.tag   = TAG_W'(tag);
      e.value = XLEN'(tag * 256);
      e.src   = SRC_W'(src);
      sb.push_back(e);
   endtask

   task automatic wait_drain(input string name, input int budget);
      for (int k = 0; k < budget && sb.size() != 0; k++) tick();
      check(name, 64'(sb.size()), 64'd0);
   endtask

   // Each FU in mask offers n results (tag = tbase + f*fstep + k*kstep, value = tag*256),
   // holding each one stable until it is accepted.
   task automatic stream(input logic [FU_NUM-1:0] mask, input int n, input int tbase,
                         input int fstep, input int kstep, output int ncyc);
      int sent [FU_NUM];
      logic [FU_NUM-1:0] rdy;
      bit busy;
      for (int f = 0; f < FU_NUM; f++) sent[f] = 0;
      ncyc = 0;
      busy = 1'b1;
      while (busy && ncyc < 50) begin
         for (int f = 0; f < FU_NUM; f++) begin
            if (mask[f] && sent[f] < n)
               present(f, 1'b1, TAG_W'(tbase + f*fstep + sent[f]*kstep),
                       XLEN'((tbase + f*fstep + sent[f]*kstep) * 256));
            else
               present(f, 1'b0, '0, '0);
         end
         @(negedge clock);
         rdy = fu_ready;
         tick();
         ncyc++;
         busy = 1'b0;
         for (int f = 0; f < FU_NUM; f++) begin
            if (fu_valid[f] && rdy[f]) sent[f]++;
            if (mask[f] && sent[f] < n) busy = 1'b1;
         end
      end
      idle();
      for (int f = 0; f < FU_NUM; f++)
         if (mask[f]) check("stream_sent", 64'(sent[f]), 64'(n));
   endtask

   always @(negedge clock) begin
      bc_t e;
      if (reset && cdb_valid) begin
         if (sb.size() == 0) begin
            check("spurious_bc", 64'(cdb_valid), 64'd0);
         end else begin
            e = sb.pop_front();
            check("bc_tag",   64'(cdb_tag),   64'(e.tag));
            check("bc_value", 64'(cdb_value), 64'(e.value));
            check("bc_src",   64'(cdb_src),   64'(e.src));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset state
      #2 reset = 1'b0;
      #1;
      check("rst_cdb_valid", 64'(cdb_valid), 64'd0);
      check("rst_cdb_tag",   64'(cdb_tag),   64'd0);
      check("rst_cdb_value", 64'(cdb_value), 64'd0);
      check("rst_cdb_src",   64'(cdb_src),   64'd0);
      check("rst_fu_ready",  64'(fu_ready),  64'b111);
      tick();
      reset = 1'b1;

      // Single result from FU1: on the CDB two cycles later, for one cycle
      present(1, 1'b1, 5'd5, 32'hDEAD_BEEF);
      begin
         bc_t e;
         e.tag = 5'd5; e.value = 32'hDEAD_BEEF; e.src = 2'd1;
         sb.push_back(e);
      end
      @(negedge clock); check("t1_ready", 64'(fu_ready), 64'b111);
      tick(); idle();
      @(negedge clock); check("t1_n1_idle", 64'(cdb_valid), 64'd0);
      tick();
      @(negedge clock); check("t1_n2_valid", 64'(cdb_valid), 64'd1);
      tick();
      @(negedge clock); check("t1_n3_idle", 64'(cdb_valid), 64'd0);
      tick();
      check("t1_drain", 64'(sb.size()), 64'd0);

      // FU2 alone moves rr_ptr from 2 through the wrap to 0
      present(2, 1'b1, 5'd4, 32'h400);
      expect_bc(4, 2);
      tick(); idle();
      wait_drain("t2_pre_drain", 6);

      // Three simultaneous requests with rr_ptr=0: broadcast 1,2,3 back to back
      present(0, 1'b1, 5'd1, 32'h100);
      present(1, 1'b1, 5'd2, 32'h200);
      present(2, 1'b1, 5'd3, 32'h300);
      expect_bc(1, 0); expect_bc(2, 1); expect_bc(3, 2);
      @(negedge clock); check("t2_ready", 64'(fu_ready), 64'b111);
      tick(); idle();
      @(negedge clock); check("t2_n1_idle", 64'(cdb_valid), 64'd0);
      for (int k = 0; k < 3; k++) begin
         tick();
         @(negedge clock); check("t2_burst_valid", 64'(cdb_valid), 64'd1);
      end
      tick();
      @(negedge clock); check("t2_after_idle", 64'(cdb_valid), 64'd0);
      tick();
      check("t2_drain", 64'(sb.size()), 64'd0);

      // FU0 and FU2 both saturating: grants alternate 0,2 starting at FU0 (rr_ptr wrapped to 0)
      for (int r = 0; r < 4; r++) begin
         expect_bc(10 + r, 0);
         expect_bc(20 + r, 2);
      end
      stream(3'b101, 4, 10, 5, 1, cycles);
      check("t3_cycles", 64'(cycles), 64'd7);
      wait_drain("t3_drain", 10);

      // Tag 0 is accepted but never broadcast; CDB payload holds the last broadcast
      present(0, 1'b1, 5'd0, 32'd7);
      @(negedge clock); check("t4_ready", 64'(fu_ready), 64'b111);
      tick(); idle();
      @(negedge clock);
      check("t4_n1_idle", 64'(cdb_valid), 64'd0);
      check("t4_hold_tag", 64'(cdb_tag), 64'd23);
      check("t4_hold_value", 64'(cdb_value), 64'(23 * 256));
      tick();
      @(negedge clock); check("t4_n2_idle", 64'(cdb_valid), 64'd0);
      tick();
      @(negedge clock); check("t4_n3_idle", 64'(cdb_valid), 64'd0);
      tick();

      // Squash with buffers 0 and 1 full; FU2's tag 9 taken in the squash cycle is dropped
      present(0, 1'b1, 5'd6, 32'h600);
      present(1, 1'b1, 5'd7, 32'h700);
      @(negedge clock); check("t5_fill_ready", 64'(fu_ready), 64'b111);
      tick(); idle();
      present(2, 1'b1, 5'd9, 32'h900);
      squash = 1'b1;
      @(negedge clock); check("t5_squash_ready", 64'(fu_ready), 64'b101);
      tick(); idle();
      squash = 1'b0;
      @(negedge clock);
      check("t5_n1_idle", 64'(cdb_valid), 64'd0);
      check("t5_bufs_empty", 64'(fu_ready), 64'b111);
      tick();
      @(negedge clock); check("t5_n2_idle", 64'(cdb_valid), 64'd0);
      tick();
      @(negedge clock); check("t5_n3_idle", 64'(cdb_valid), 64'd0);
      tick();
      check("t5_no_bc", 64'(sb.size()), 64'd0);

      // Sole requester FU1 sustains one result per cycle
      for (int k = 1; k <= 4; k++) expect_bc(k, 1);
      stream(3'b010, 4, 0, 1, 1, cycles);
      check("t6_cycles", 64'(cycles), 64'd4);
      @(negedge clock); check("t6_b4_valid", 64'(cdb_valid), 64'd1);
      tick();
      @(negedge clock); check("t6_b5_valid", 64'(cdb_valid), 64'd1);
      tick();
      @(negedge clock); check("t6_b6_idle", 64'(cdb_valid), 64'd0);
      tick();
      check("t6_drain", 64'(sb.size()), 64'd0);

      // Reset mid-operation: buffered result is lost, outputs clear immediately
      present(0, 1'b1, 5'd3, 32'h300);
      tick(); idle();
      #2 reset = 1'b0;
      #1;
      check("t7_cdb_valid", 64'(cdb_valid), 64'd0);
      check("t7_cdb_tag",   64'(cdb_tag),   64'd0);
      check("t7_fu_ready",  64'(fu_ready),  64'b111);
      tick();
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clock); check("t7_idle", 64'(cdb_valid), 64'd0);
         tick();
      end

      // All three FUs saturating: strict rotation 0,1,2 with tags 1..9
      for (int t = 1; t <= 9; t++) expect_bc(t, (t - 1) % 3);
      stream(3'b111, 3, 1, 1, 3, cycles);
      check("t8_cycles", 64'(cycles), 64'd7);
      wait_drain("t8_drain", 10);
`ifdef CDB_ARB_PERF_EN
      check("perf_fu0", 64'(perf_stall_cnt[0 +: 16]),  64'd2);
      check("perf_fu1", 64'(perf_stall_cnt[16 +: 16]), 64'd3);
      check("perf_fu2", 64'(perf_stall_cnt[32 +: 16]), 64'd4);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
